// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: instruction encodings, widths and FSM states.
// The `NOP and `HALT encodings live here so every file that imports the package sees them.
`ifndef FETCH_STAGE_MACROS
`define FETCH_STAGE_MACROS
`define NOP  16'h0000
`define HALT 16'hFFFF
`endif

package fetch_stage_pkg;
    localparam int IR_BITS        = 16;
    localparam int DEFAULT_A_BITS = 10;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_unit.sv
// Program counter register for the fetch stage.
// Supports load (branch), hold (stall/halt), increment and asynchronous reset.
module pc_unit
    import fetch_stage_pkg::*;
#(
    parameter int                  A_BITS   = DEFAULT_A_BITS,
    parameter logic [A_BITS-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              hold,
    input  logic [A_BITS-1:0] load_addr,
    output logic [A_BITS-1:0] pc
);

    // A load takes priority over hold; the increment wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (!hold) begin
            pc <= pc + A_BITS'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// First pipeline stage: owns the PC, registers the fetched word into IR and handles HALT.
// Optional FETCH_PERF_CNT_EN adds saturating stall and flush counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  A_BITS   = DEFAULT_A_BITS,
    parameter logic [A_BITS-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [A_BITS-1:0]  br_target,
    output logic [A_BITS-1:0]  imem_addr,
    input  logic [IR_BITS-1:0] imem_data,
    output logic [IR_BITS-1:0] IR,
    output logic [A_BITS-1:0]  pc_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic               halted
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic              running;
    logic              do_flush;
    logic              do_stall;
    logic              do_fetch;
    logic              pc_load;
    logic              pc_hold;
    logic [A_BITS-1:0] pc;

    assign running   = (state == RUN);
    assign do_flush  = running && br_taken;
    assign do_stall  = running && !br_taken && stall;
    assign do_fetch  = running && !br_taken && !stall;
    assign pc_load   = do_flush;
    assign pc_hold   = !running || stall;
    assign imem_addr = pc;
    assign halted    = !running;

    pc_unit #(
        .A_BITS   (A_BITS),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .hold      (pc_hold),
        .load_addr (br_target),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // HALTED is entered on the same edge that captures the HALT word.
    always_comb begin
        state_next = state;
        if (do_fetch && (imem_data == `HALT)) begin
            state_next = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IR     <= `NOP;
            pc_out <= '0;
        end else if (!running) begin
            IR <= `NOP;
        end else if (do_flush) begin
            IR     <= `NOP;
            pc_out <= '0;
        end else if (do_fetch) begin
            IR     <= imem_data;
            pc_out <= pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (do_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [15:0] TB_NOP  = 16'h0000;
    localparam logic [15:0] TB_HALT = 16'hFFFF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [9:0]  br_target;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] IR;
    logic [9:0]  pc_out;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [15:0] imem [0:1023];

    int check_count = 0;
    int pass_count  = 0;

    assign imem_data = imem[imem_addr];

    fetch_stage #(
        .A_BITS   (10),
        .RESET_PC (10'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .IR        (IR),
        .pc_out    (pc_out),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, then advance one rising edge and sample at the next falling edge.
    task automatic applyStimulus(input logic s, input logic b, input logic [9:0] t);
        stall     = s;
        br_taken  = b;
        br_target = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkFetch(input string tag, input logic [15:0] ir_exp,
                              input logic [9:0] pc_exp, input logic [9:0] addr_exp);
        checkOutput({tag, ".IR"}, 32'(IR), 32'(ir_exp));
        checkOutput({tag, ".pc_out"}, 32'(pc_out), 32'(pc_exp));
        checkOutput({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr_exp));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 16'(i) ^ 16'h1000;
        imem[0]      = 16'h8050;
        imem[1]      = 16'h8011;
        imem[2]      = 16'h0123;
        imem[3]      = 16'h4567;
        imem[4]      = 16'h1111;
        imem[10'h3F0] = 16'hABCD;
        imem[10'h3FF] = 16'h5A5A;

        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);

        checkFetch("reset", TB_NOP, 10'd0, 10'd0);
        checkOutput("reset.halted", 32'(halted), 32'd0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("seq0", 16'h8050, 10'd0, 10'd1);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("seq1", 16'h8011, 10'd1, 10'd2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd0);
            checkFetch("stall", 16'h8011, 10'd1, 10'd2);
        end

        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("seq2", 16'h0123, 10'd2, 10'd3);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("seq3", 16'h4567, 10'd3, 10'd4);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("seq4", 16'h1111, 10'd4, 10'd5);

        applyStimulus(1'b1, 1'b1, 10'h3F0);
        checkFetch("flush_stall", TB_NOP, 10'd0, 10'h3F0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("target", 16'hABCD, 10'h3F0, 10'h3F1);

        applyStimulus(1'b0, 1'b1, 10'h3FF);
        checkFetch("br_3ff", TB_NOP, 10'd0, 10'h3FF);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("wrap", 16'h5A5A, 10'h3FF, 10'd0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("after_wrap", 16'h8050, 10'd0, 10'd1);
        applyStimulus(1'b1, 1'b0, 10'd0);
        checkFetch("stall4", 16'h8050, 10'd0, 10'd1);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("stall_cnt", 32'(stall_cnt), 32'd4);
        checkOutput("flush_cnt", 32'(flush_cnt), 32'd2);
`endif

        // Asynchronous reset mid-operation, then HALT run.
        rst_n = 1'b0;
        #1;
        checkFetch("async_reset", TB_NOP, 10'd0, 10'd0);
        imem[4] = TB_HALT;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("pre_halt", 16'h4567, 10'd3, 10'd4);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("halt_cap", TB_HALT, 10'd4, 10'd5);
        checkOutput("halt_cap.halted", 32'(halted), 32'd1);
        applyStimulus(1'b0, 1'b1, 10'h100);
        checkOutput("halted_br.IR", 32'(IR), 32'(TB_NOP));
        checkOutput("halted_br.imem_addr", 32'(imem_addr), 32'd5);
        checkOutput("halted_br.halted", 32'(halted), 32'd1);
        applyStimulus(1'b1, 1'b0, 10'd0);
        checkOutput("halted_stall.IR", 32'(IR), 32'(TB_NOP));
        checkOutput("halted_stall.imem_addr", 32'(imem_addr), 32'd5);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("halted.stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("halted.flush_cnt", 32'(flush_cnt), 32'd0);
`endif

        stall    = 1'b0;
        br_taken = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("unhalt.imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("unhalt.halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Branch in the same cycle as the HALT word wins: no capture, stays RUN.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 10'd0);
        checkOutput("pre_halt2.imem_addr", 32'(imem_addr), 32'd4);
        applyStimulus(1'b0, 1'b1, 10'd2);
        checkFetch("br_over_halt", TB_NOP, 10'd0, 10'd2);
        checkOutput("br_over_halt.halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkFetch("post_br", 16'h0123, 10'd2, 10'd3);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
